// File: rtl/cam_row_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cam_row_decoder_pkg
// Description : Shared CAM definitions. Provides the default geometry, the
//               write-side command opcodes and the row-decoder state encoding.
//               The match-side priority encoder uses the same widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_row_decoder_pkg;

  localparam int CAM_ENTRIES = 128;
  localparam int CAM_IDX_W   = 7;
  localparam int CAM_KEY_W   = 32;

  typedef enum logic [1:0] {
    CAM_NOP   = 2'd0,
    CAM_WRITE = 2'd1,
    CAM_INVAL = 2'd2,
    CAM_FLUSH = 2'd3
  } cam_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } cam_state_e;

endpackage : cam_row_decoder_pkg
`default_nettype wire

// File: rtl/cam_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : cam_onehot_dec
// Description : Index to one-hot row decoder. The output is all-zero when the
//               enable is low or when the index names a row that does not
//               exist (idx >= ENTRIES).
// Ports       : en_i     - decode enable
//               idx_i    - row index
//               onehot_o - one-hot row select, at most one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module cam_onehot_dec
  import cam_row_decoder_pkg::*;
#(
  parameter int IDX_W   = CAM_IDX_W,
  parameter int ENTRIES = CAM_ENTRIES
) (
  input  logic               en_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [ENTRIES-1:0] onehot_o
);

  // Only rows 0..ENTRIES-1 get a comparator, so out-of-range indices
  // naturally decode to zero.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_row
    localparam logic [IDX_W-1:0] c_row = IDX_W'(i);
    assign onehot_o[i] = en_i & (idx_i == c_row);
  end

endmodule : cam_onehot_dec
`default_nettype wire

// File: rtl/cam_row_decoder.sv
`default_nettype none
// ============================================================================
// Module      : cam_row_decoder
// Description : Write-side address decoder for the CAM. Decodes WRITE / INVAL
//               commands into a registered one-hot row write strobe with key
//               data, owns the per-entry valid vector, and runs a FLUSH sweep
//               that clears one row per cycle.
// Ports       : clk_i          - clock, rising edge
//               rst_ni         - asynchronous active-low reset
//               cmd_valid_i    - command present
//               cmd_ready_o    - command can be accepted (idle)
//               cmd_op_i       - 0 NOP, 1 WRITE, 2 INVAL, 3 FLUSH
//               cmd_idx_i      - target entry for WRITE / INVAL
//               cmd_key_i      - key for WRITE
//               row_we_o       - one-hot row write strobe
//               row_key_o      - data written with row_we_o
//               valid_vec_o    - per-entry valid bits
//               busy_o         - flush sweep in progress
//               flush_done_o   - pulse with the last flush strobe
//               err_idx_o      - pulse: WRITE / INVAL with out-of-range index
// Revision    : 1.0 - initial release
// ============================================================================
module cam_row_decoder
  import cam_row_decoder_pkg::*;
#(
  parameter int ENTRIES = CAM_ENTRIES,
  parameter int IDX_W   = CAM_IDX_W,
  parameter int KEY_W   = CAM_KEY_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [IDX_W-1:0]   cmd_idx_i,
  input  logic [KEY_W-1:0]   cmd_key_i,
  output logic [ENTRIES-1:0] row_we_o,
  output logic [KEY_W-1:0]   row_key_o,
  output logic [ENTRIES-1:0] valid_vec_o,
  output logic               busy_o,
  output logic               flush_done_o,
  output logic               err_idx_o
);

  // One extra bit so ENTRIES == 2**IDX_W is representable.
  localparam logic [IDX_W:0]   c_entries = (IDX_W+1)'(ENTRIES);
  localparam logic [IDX_W-1:0] c_last    = IDX_W'(ENTRIES - 1);

  cam_state_e         state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [ENTRIES-1:0] row_we_q, row_we_d;
  logic [KEY_W-1:0]   row_key_q, row_key_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  cam_op_e            w_op;
  logic               w_accept;
  logic               w_is_rw;
  logic               w_idx_ok;
  logic               w_cmd_en;
  logic               w_sweep_start;
  logic               w_last;
  logic               w_sweep_en;
  logic [IDX_W-1:0]   w_sweep_idx;
  logic [ENTRIES-1:0] w_cmd_oh;
  logic [ENTRIES-1:0] w_sweep_oh;

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q == ST_FLUSH);

  assign w_op          = cam_op_e'(cmd_op_i);
  assign w_accept      = cmd_valid_i & cmd_ready_o;
  assign w_is_rw       = w_accept & ((w_op == CAM_WRITE) | (w_op == CAM_INVAL));
  assign w_idx_ok      = ({1'b0, cmd_idx_i} < c_entries);
  assign w_cmd_en      = w_is_rw & w_idx_ok;
  assign w_sweep_start = w_accept & (w_op == CAM_FLUSH);
  assign w_last        = (cnt_q == c_last);

  // The sweep decoder is driven with the row that will be strobed next cycle,
  // so the registered strobe lines up with the counter value it belongs to:
  // row 0 on entry, then cnt_q+1 while still inside the sweep.
  assign w_sweep_en    = w_sweep_start | (busy_o & ~w_last);
  assign w_sweep_idx   = busy_o ? (cnt_q + IDX_W'(1)) : '0;

  cam_onehot_dec #(
    .IDX_W   (IDX_W),
    .ENTRIES (ENTRIES)
  ) u_cmd_dec (
    .en_i     (w_cmd_en),
    .idx_i    (cmd_idx_i),
    .onehot_o (w_cmd_oh)
  );

  cam_onehot_dec #(
    .IDX_W   (IDX_W),
    .ENTRIES (ENTRIES)
  ) u_sweep_dec (
    .en_i     (w_sweep_en),
    .idx_i    (w_sweep_idx),
    .onehot_o (w_sweep_oh)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_we_d  = '0;
    row_key_d = '0;
    valid_d   = valid_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        row_we_d = w_cmd_oh;
        err_d    = w_is_rw & ~w_idx_ok;
        if (w_cmd_en && (w_op == CAM_WRITE)) begin
          row_key_d = cmd_key_i;
          valid_d   = valid_q | w_cmd_oh;
        end
        if (w_cmd_en && (w_op == CAM_INVAL)) begin
          valid_d = valid_q & ~w_cmd_oh;
        end
        if (w_sweep_start) begin
          state_d  = ST_FLUSH;
          cnt_d    = '0;
          row_we_d = w_sweep_oh;
          valid_d  = valid_q & ~w_sweep_oh;
        end
      end
      ST_FLUSH: begin
        if (w_last) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d    = w_sweep_idx;
          row_we_d = w_sweep_oh;
          valid_d  = valid_q & ~w_sweep_oh;
          // Done is raised alongside the strobe of the final row.
          done_d   = (w_sweep_idx == c_last);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      row_we_q  <= '0;
      row_key_q <= '0;
      valid_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_we_q  <= row_we_d;
      row_key_q <= row_key_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign row_we_o     = row_we_q;
  assign row_key_o    = row_key_q;
  assign valid_vec_o  = valid_q;
  assign flush_done_o = done_q;
  assign err_idx_o    = err_q;

endmodule : cam_row_decoder
`default_nettype wire

// File: tb/tb_cam_row_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_row_decoder
// Description : Self-checking bench for cam_row_decoder. A 128-entry instance
//               is checked every cycle against a behavioural model; a
//               100-entry instance exercises out-of-range indices and a
//               shorter sweep with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_row_decoder;
  import cam_row_decoder_pkg::*;

  localparam int E = 128;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;

  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd_op    = 2'd0;
  logic [6:0]   cmd_idx   = 7'd0;
  logic [31:0]  cmd_key   = 32'd0;
  logic         cmd_ready;
  logic [127:0] row_we;
  logic [31:0]  row_key;
  logic [127:0] valid_vec;
  logic         busy, flush_done, err_idx;

  logic         b_valid = 1'b0;
  logic [1:0]   b_op    = 2'd0;
  logic [6:0]   b_idx   = 7'd0;
  logic [31:0]  b_key   = 32'd0;
  logic         b_ready;
  logic [99:0]  b_row_we;
  logic [31:0]  b_row_key;
  logic [99:0]  b_valid_vec;
  logic         b_busy, b_done, b_err;

  always #5 clk = ~clk;

  cam_row_decoder #(.ENTRIES(128), .IDX_W(7), .KEY_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_idx_i(cmd_idx), .cmd_key_i(cmd_key),
    .row_we_o(row_we), .row_key_o(row_key), .valid_vec_o(valid_vec),
    .busy_o(busy), .flush_done_o(flush_done), .err_idx_o(err_idx)
  );

  cam_row_decoder #(.ENTRIES(100), .IDX_W(7), .KEY_W(32)) dut100 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(b_valid), .cmd_ready_o(b_ready), .cmd_op_i(b_op),
    .cmd_idx_i(b_idx), .cmd_key_i(b_key),
    .row_we_o(b_row_we), .row_key_o(b_row_key), .valid_vec_o(b_valid_vec),
    .busy_o(b_busy), .flush_done_o(b_done), .err_idx_o(b_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model of the 128-entry instance ----------------
  // m_sweep is the row being shown as swept this cycle, -1 when not sweeping.
  logic [127:0] m_valid = '0;
  logic [127:0] m_we    = '0;
  logic [31:0]  m_key   = '0;
  bit           m_err   = 1'b0;
  bit           m_done  = 1'b0;
  int           m_sweep = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = '0; m_we = '0; m_key = '0; m_err = 0; m_done = 0; m_sweep = -1;
    end else begin
      m_we = '0; m_key = '0; m_err = 0; m_done = 0;
      if (m_sweep >= 0) begin
        if (m_sweep == E - 1) m_sweep = -1;
        else begin
          m_sweep = m_sweep + 1;
          m_we[m_sweep]    = 1'b1;
          m_valid[m_sweep] = 1'b0;
          m_done = (m_sweep == E - 1);
        end
      end else if (cmd_valid) begin
        case (int'(cmd_op))
          1: if (int'(cmd_idx) < E) begin
               m_we[cmd_idx] = 1'b1; m_key = cmd_key; m_valid[cmd_idx] = 1'b1;
             end else m_err = 1;
          2: if (int'(cmd_idx) < E) begin
               m_we[cmd_idx] = 1'b1; m_valid[cmd_idx] = 1'b0;
             end else m_err = 1;
          3: begin
               m_sweep = 0; m_we[0] = 1'b1; m_valid[0] = 1'b0;
             end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  int n_s127 = 0, n_w9 = 0, n_busy_strobes = 0, n_busy_cyc = 0, n_done = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("row_we",     row_we,                 m_we);
      chk("row_key",    128'(row_key),          128'(m_key));
      chk("valid_vec",  valid_vec,              m_valid);
      chk("busy",       128'(busy),             128'(m_sweep >= 0));
      chk("cmd_ready",  128'(cmd_ready),        128'(m_sweep < 0));
      chk("flush_done", 128'(flush_done),       128'(m_done));
      chk("err_idx",    128'(err_idx),          128'(m_err));
      if (row_we[127])           n_s127++;
      if (!busy && row_we[9])    n_w9++;
      if (busy && (|row_we))     n_busy_strobes++;
      if (busy)                  n_busy_cyc++;
      if (flush_done)            n_done++;
    end
  end

  // Offer a command from a falling edge and hold it until accepted.
  task automatic send(input logic [1:0] op, input logic [6:0] idx, input logic [31:0] key);
    bit acc;
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_key = key;
    for (int i = 0; i < 400; i++) begin
      acc = cmd_ready;
      @(negedge clk);
      if (acc) return;
    end
    chk("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd_op = 2'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_s127, b_w9, b_bs, b_bc, b_dn, seen, cyc, dn;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    #1;
    chk("rst_ready", 128'(cmd_ready), 128'(1));
    chk("rst_valid", valid_vec, 128'(0));
    chk("rst_we",    row_we,    128'(0));
    chk("rst_busy",  128'(busy), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Single write
    send(CAM_WRITE, 7'd5, 32'hDEADBEEF); idle(); #1;
    chk("wr5_we",    row_we,          128'h20);
    chk("wr5_key",   128'(row_key),   128'hDEADBEEF);
    chk("wr5_valid", valid_vec,       128'h20);

    // Write then invalidate the top row back to back
    b_s127 = n_s127;
    send(CAM_WRITE, 7'd127, 32'h12345678);
    send(CAM_INVAL, 7'd127, 32'hFFFFFFFF); idle(); #1;
    chk("inv127_we",    row_we,        {1'b1, 127'b0});
    chk("inv127_key",   128'(row_key), 128'(0));
    chk("inv127_valid", valid_vec,     128'h20);
    @(negedge clk); #1;
    chk("s127_twice", 128'(n_s127 - b_s127), 128'(2));

    // Assorted directed commands (model checks every cycle)
    send(CAM_NOP,   7'd9,  32'h1);
    send(CAM_INVAL, 7'd3,  32'h2);
    send(CAM_WRITE, 7'd5,  32'hCAFEF00D);
    send(CAM_WRITE, 7'd20, 32'h11111111);
    send(CAM_WRITE, 7'd20, 32'h22222222);
    send(CAM_WRITE, 7'd0,  32'h0A0A0A0A);
    send(CAM_WRITE, 7'd64, 32'h40404040);
    send(CAM_WRITE, 7'd127,32'h7F7F7F7F); idle(); #1;
    chk("pre_flush_valid", valid_vec,
        {1'b1, 62'b0, 1'b1, 43'b0, 1'b1, 14'b0, 1'b1, 4'b0, 1'b1});

    // Flush with a write held off until the sweep ends
    b_w9 = n_w9; b_bs = n_busy_strobes; b_bc = n_busy_cyc; b_dn = n_done;
    send(CAM_FLUSH, 7'd0, 32'h0);
    send(CAM_WRITE, 7'd9, 32'hAAAA5555); idle();
    repeat (2) @(negedge clk); #1;
    chk("flush_strobes", 128'(n_busy_strobes - b_bs), 128'(128));
    chk("flush_cycles",  128'(n_busy_cyc - b_bc),     128'(128));
    chk("flush_done_n",  128'(n_done - b_dn),         128'(1));
    chk("held_wr_once",  128'(n_w9 - b_w9),           128'(1));
    chk("post_flush_valid", valid_vec, 128'h200);

    // Reset in the middle of a sweep
    b_dn = n_done;
    send(CAM_FLUSH, 7'd0, 32'h0); idle();
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      if (row_we[40]) seen = 1;
      else @(negedge clk);
    end
    chk("row40_seen", 128'(seen), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    row_we,    128'(0));
    chk("mid_rst_valid", valid_vec, 128'(0));
    chk("mid_rst_busy",  128'(busy), 128'(0));
    chk("mid_rst_ready", 128'(cmd_ready), 128'(1));
    chk("mid_rst_done",  128'(flush_done), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk); #1;
    chk("mid_rst_no_done", 128'(n_done - b_dn), 128'(0));
    chk("mid_rst_ready2",  128'(cmd_ready), 128'(1));
    send(CAM_WRITE, 7'd7, 32'h77777777); idle(); #1;
    chk("post_rst_wr7", valid_vec, 128'h80);

    // 100-entry instance: out-of-range index, top row, short sweep
    cmp_en = 1'b0;
    @(negedge clk);
    b_valid = 1'b1; b_op = CAM_WRITE; b_idx = 7'd100; b_key = 32'h5A5A5A5A;
    @(negedge clk); b_valid = 1'b0; #1;
    chk("e100_err",   128'(b_err),       128'(1));
    chk("e100_we",    128'(b_row_we),    128'(0));
    chk("e100_valid", 128'(b_valid_vec), 128'(0));
    @(negedge clk); #1;
    chk("e100_err_pulse", 128'(b_err), 128'(0));
    b_valid = 1'b1; b_op = CAM_WRITE; b_idx = 7'd99; b_key = 32'h99999999;
    @(negedge clk); b_valid = 1'b0; #1;
    chk("e99_we",    128'(b_row_we),    128'({1'b1, 99'b0}));
    chk("e99_key",   128'(b_row_key),   128'h99999999);
    chk("e99_valid", 128'(b_valid_vec), 128'({1'b1, 99'b0}));
    b_valid = 1'b1; b_op = CAM_FLUSH; b_idx = 7'd0;
    @(negedge clk); b_valid = 1'b0;
    cyc = 0; dn = 0;
    for (int i = 0; i < 300 && b_busy; i++) begin
      cyc++;
      if (b_done) dn++;
      @(negedge clk);
    end
    chk("e100_sweep_len", 128'(cyc), 128'(100));
    chk("e100_done",      128'(dn),  128'(1));
    chk("e100_cleared",   128'(b_valid_vec), 128'(0));
    chk("e100_ready",     128'(b_ready), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_cam_row_decoder
`default_nettype wire
